instr_fetch_unit: RTL and testbench

Instruction fetch stage of the KGP-RISC multicycle processor. Owns the PC, NPC and IR registers and runs a req/ack handshake to a variable-latency instruction memory. It is driven by the controller's readim/ldir/ldnpc/ldpc/branch strobes and feeds irout back to the controller and datapath. It stalls the controller while a fetch is outstanding, detects the halt word, and aborts on a memory timeout.

---
 rtl/instr_fetch_unit.sv | 218 +++++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : KGP-RISC instruction fetch stage. Owns PC/NPC/IR, runs a
//            req/ack handshake to a variable-latency instruction memory,
//            stalls the controller, detects the halt word and aborts on a
//            memory timeout.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        readim,
  input  logic        ldir,
  input  logic        ldnpc,
  input  logic        ldpc,
  input  logic        branch,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] irout,
  output logic [31:0] npc,
  output logic [31:0] pc,
  output logic        fetch_busy,
  output logic        halted,
  output logic        fetch_err
);

  // Timeout counter is 8 bits wide, enough for TIMEOUT up to 255.
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  // Internal registers
  logic        armed;
  logic        buf_valid;
  logic        ldir_pend;
  logic [31:0] fetch_buf;
  logic [7:0]  wait_cnt;

  // Next-state values
  logic [31:0] pc_next;
  logic [31:0] npc_next;
  logic [31:0] ir_next;
  logic        req_next;
  logic [31:0] addr_next;
  logic        halted_next;
  logic        err_next;
  logic        armed_next;
  logic        buf_valid_next;
  logic        ldir_pend_next;
  logic [31:0] fetch_buf_next;
  logic [7:0]  wait_cnt_next;

  // IR load request: either an earlier ldir that is still pending or one
  // arriving at this very edge.
  logic        want_ir;
  logic        load_en;
  logic [31:0] load_word;

  assign want_ir = ldir_pend | ldir;

  // Stall only while an IR load is waiting on a fetch that is in flight or
  // about to be issued; built from registers so imem_ack never reaches it.
  assign fetch_busy = ldir_pend & ~buf_valid &
                      ((state == REQ) | ((state == IDLE) & armed));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and register-update logic for the whole fetch stage.
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    npc_next       = npc;
    ir_next        = irout;
    req_next       = imem_req;
    addr_next      = imem_addr;
    halted_next    = halted;
    err_next       = fetch_err;
    armed_next     = armed;
    buf_valid_next = buf_valid;
    ldir_pend_next = ldir_pend;
    fetch_buf_next = fetch_buf;
    wait_cnt_next  = wait_cnt;
    load_en        = 1'b0;
    load_word      = fetch_buf;

    if (state != HALT) begin
      if (ldir) begin
        ldir_pend_next = 1'b1;
      end
      if (ldnpc) begin
        npc_next = pc + 32'd4;
      end
    end

    if ((state != HALT) && ldpc) begin
      // A PC update flushes anything in flight or buffered and cancels a
      // same-edge IR load; a coincident ack is simply dropped.
      pc_next        = branch ? branch_target : npc;
      armed_next     = 1'b1;
      buf_valid_next = 1'b0;
      ldir_pend_next = 1'b0;
      req_next       = 1'b0;
      state_next     = IDLE;
    end else begin
      case (state)
        IDLE: begin
          // Exactly one fetch per PC update: readim is level-held, so the
          // armed flag gates it.
          if (readim && armed) begin
            req_next      = 1'b1;
            addr_next     = pc;
            armed_next    = 1'b0;
            wait_cnt_next = 8'd0;
            state_next    = REQ;
          end
        end
        REQ: begin
          if (imem_ack) begin
            req_next = 1'b0;
            if (want_ir) begin
              load_en   = 1'b1;
              load_word = imem_rdata;
            end else begin
              fetch_buf_next = imem_rdata;
              buf_valid_next = 1'b1;
              state_next     = HOLD;
            end
          end else if (wait_cnt == TIMEOUT_CNT) begin
            req_next    = 1'b0;
            err_next    = 1'b1;
            halted_next = 1'b1;
            ir_next     = HALT_WORD;
            state_next  = HALT;
          end else begin
            wait_cnt_next = wait_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (want_ir) begin
            load_en   = 1'b1;
            load_word = fetch_buf;
          end
        end
        default: begin
          // HALT: frozen until reset.
        end
      endcase
    end

    if (load_en) begin
      ir_next        = load_word;
      ldir_pend_next = 1'b0;
      buf_valid_next = 1'b0;
      if (load_word == HALT_WORD) begin
        halted_next = 1'b1;
        state_next  = HALT;
      end else begin
        state_next  = IDLE;
      end
    end
  end

  // Datapath and flag registers; reset drops imem_req immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= RESET_PC;
      npc       <= 32'd0;
      irout     <= 32'd0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      halted    <= 1'b0;
      fetch_err <= 1'b0;
      armed     <= 1'b1;
      buf_valid <= 1'b0;
      ldir_pend <= 1'b0;
      fetch_buf <= 32'd0;
      wait_cnt  <= 8'd0;
    end else begin
      pc        <= pc_next;
      npc       <= npc_next;
      irout     <= ir_next;
      imem_req  <= req_next;
      imem_addr <= addr_next;
      halted    <= halted_next;
      fetch_err <= err_next;
      armed     <= armed_next;
      buf_valid <= buf_valid_next;
      ldir_pend <= ldir_pend_next;
      fetch_buf <= fetch_buf_next;
      wait_cnt  <= wait_cnt_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Directed self-checking bench for instr_fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        readim;
  logic        ldir;
  logic        ldnpc;
  logic        ldpc;
  logic        branch;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] irout;
  logic [31:0] npc;
  logic [31:0] pc;
  logic        fetch_busy;
  logic        halted;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0100),
    .HALT_WORD(32'hFFFF_FFFF),
    .TIMEOUT  (15)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .readim       (readim),
    .ldir         (ldir),
    .ldnpc        (ldnpc),
    .ldpc         (ldpc),
    .branch       (branch),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .irout        (irout),
    .npc          (npc),
    .pc           (pc),
    .fetch_busy   (fetch_busy),
    .halted       (halted),
    .fetch_err    (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; readim = 1'b0; ldir = 1'b0; ldnpc = 1'b0; ldpc = 1'b0;
    branch = 1'b0; branch_target = 32'd0; imem_ack = 1'b0; imem_rdata = 32'd0;

    // Reset state
    step();
    check("rst_pc", pc, 32'h100);
    check("rst_npc", npc, 32'h0);
    check("rst_ir", irout, 32'h0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h100);
    check("rst_busy", {31'd0, fetch_busy}, 32'd0);
    check("rst_halt", {31'd0, halted}, 32'd0);
    check("rst_err", {31'd0, fetch_err}, 32'd0);
    reset = 1'b1;
    step();

    // Zero-wait fetch
    readim = 1'b1; ldir = 1'b1;
    step();
    check("zw_req", {31'd0, imem_req}, 32'd1);
    check("zw_addr", imem_addr, 32'h100);
    check("zw_busy", {31'd0, fetch_busy}, 32'd1);
    readim = 1'b0; ldir = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0400_0001;
    step();
    imem_ack = 1'b0;
    check("zw_ir", irout, 32'h0400_0001);
    check("zw_req_drop", {31'd0, imem_req}, 32'd0);
    check("zw_busy_drop", {31'd0, fetch_busy}, 32'd0);
    readim = 1'b1;
    step();
    check("one_fetch_per_pc", {31'd0, imem_req}, 32'd0);
    readim = 1'b0;

    // Sequential PC update
    ldnpc = 1'b1;
    step();
    ldnpc = 1'b0;
    check("npc_plus4", npc, 32'h104);
    ldpc = 1'b1; branch = 1'b0;
    step();
    ldpc = 1'b0;
    check("pc_from_npc", pc, 32'h104);

    // Fetch with 3 memory wait cycles
    readim = 1'b1; ldir = 1'b1;
    step();
    readim = 1'b0; ldir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("w3_req_%0d", i), {31'd0, imem_req}, 32'd1);
      check($sformatf("w3_addr_%0d", i), imem_addr, 32'h104);
      check($sformatf("w3_busy_%0d", i), {31'd0, fetch_busy}, 32'd1);
      if (i == 3) begin
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
      end
      step();
    end
    imem_ack = 1'b0;
    check("w3_ir", irout, 32'h1234_5678);
    check("w3_req_drop", {31'd0, imem_req}, 32'd0);
    check("w3_busy_drop", {31'd0, fetch_busy}, 32'd0);

    // Branch, then fetch into the buffer and load IR later
    ldpc = 1'b1; branch = 1'b1; branch_target = 32'h40;
    step();
    ldpc = 1'b0; branch = 1'b0;
    check("br_pc", pc, 32'h40);
    readim = 1'b1;
    step();
    readim = 1'b0;
    check("br_req", {31'd0, imem_req}, 32'd1);
    check("br_addr", imem_addr, 32'h40);
    check("br_busy_noldir", {31'd0, fetch_busy}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'hAAAA_5555;
    step();
    imem_ack = 1'b0;
    check("buf_req_drop", {31'd0, imem_req}, 32'd0);
    check("buf_ir_hold", irout, 32'h1234_5678);
    ldir = 1'b1;
    step();
    ldir = 1'b0;
    check("buf_ir_load", irout, 32'hAAAA_5555);

    // ldpc during REQ flushes a coincident ack
    ldnpc = 1'b1;
    step();
    ldnpc = 1'b0;
    check("npc_44", npc, 32'h44);
    ldpc = 1'b1;
    step();
    ldpc = 1'b0;
    check("pc_44", pc, 32'h44);
    readim = 1'b1; ldir = 1'b1;
    step();
    readim = 1'b0; ldir = 1'b0;
    check("fl_addr", imem_addr, 32'h44);
    ldpc = 1'b1; branch = 1'b1; branch_target = 32'h80;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    ldpc = 1'b0; branch = 1'b0;
    check("fl_pc", pc, 32'h80);
    check("fl_req", {31'd0, imem_req}, 32'd0);
    check("fl_ir_keep", irout, 32'hAAAA_5555);
    check("fl_busy", {31'd0, fetch_busy}, 32'd0);
    step();
    imem_ack = 1'b0;
    check("idle_ack_ignored", irout, 32'hAAAA_5555);
    readim = 1'b1; ldir = 1'b1;
    step();
    readim = 1'b0; ldir = 1'b0;
    check("fl_new_req", {31'd0, imem_req}, 32'd1);
    check("fl_new_addr", imem_addr, 32'h80);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
    step();
    imem_ack = 1'b0;
    check("fl_new_ir", irout, 32'h0000_0013);

    // NPC wraps around
    ldpc = 1'b1; branch = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    ldpc = 1'b0; branch = 1'b0;
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    ldnpc = 1'b1;
    step();
    ldnpc = 1'b0;
    check("wrap_npc", npc, 32'h0);

    // Halt word
    readim = 1'b1; ldir = 1'b1;
    step();
    readim = 1'b0; ldir = 1'b0;
    check("halt_addr", imem_addr, 32'hFFFF_FFFC);
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    step();
    imem_ack = 1'b0;
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_ir", irout, 32'hFFFF_FFFF);
    check("halt_noerr", {31'd0, fetch_err}, 32'd0);
    readim = 1'b1; ldir = 1'b1; ldpc = 1'b1; branch = 1'b1;
    branch_target = 32'h200; ldnpc = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("halt_noreq_%0d", i), {31'd0, imem_req}, 32'd0);
      check($sformatf("halt_pc_%0d", i), pc, 32'hFFFF_FFFC);
      check($sformatf("halt_npc_%0d", i), npc, 32'h0);
    end
    readim = 1'b0; ldir = 1'b0; ldpc = 1'b0; branch = 1'b0; ldnpc = 1'b0;

    // Timeout
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("to_rst_halt", {31'd0, halted}, 32'd0);
    readim = 1'b1; ldir = 1'b1;
    step();
    readim = 1'b0; ldir = 1'b0;
    check("to_addr", imem_addr, 32'h100);
    for (int i = 0; i < 15; i++) begin
      step();
      check($sformatf("to_wait_req_%0d", i), {31'd0, imem_req}, 32'd1);
      check($sformatf("to_wait_err_%0d", i), {31'd0, fetch_err}, 32'd0);
    end
    step();
    check("to_err", {31'd0, fetch_err}, 32'd1);
    check("to_halt", {31'd0, halted}, 32'd1);
    check("to_ir", irout, 32'hFFFF_FFFF);
    check("to_req", {31'd0, imem_req}, 32'd0);

    // Asynchronous reset in the middle of a request
    reset = 1'b0;
    step();
    reset = 1'b1;
    readim = 1'b1; ldir = 1'b1;
    step();
    readim = 1'b0; ldir = 1'b0;
    check("ar_req_before", {31'd0, imem_req}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_req", {31'd0, imem_req}, 32'd0);
    check("ar_pc", pc, 32'h100);
    check("ar_npc", npc, 32'h0);
    check("ar_ir", irout, 32'h0);
    check("ar_busy", {31'd0, fetch_busy}, 32'd0);
    check("ar_halt", {31'd0, halted}, 32'd0);
    check("ar_err", {31'd0, fetch_err}, 32'd0);
    reset = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'h0000_0055;
    step();
    imem_ack = 1'b0;
    check("ar_late_ack_ir", irout, 32'h0);
    check("ar_late_ack_req", {31'd0, imem_req}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
